// File: rtl/msg_pkg.sv
// Shared types and default address map for the message stream sink.
package msg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } msg_state_t;

    localparam logic [31:0] MSG_BASE_DEF  = 32'h0000_4600;
    localparam logic [31:0] MSG_LIMIT_DEF = 32'h0000_5000;
    localparam logic [31:0] END_ADR_DEF   = 32'h0000_5200;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; pointers carry one extra wrap bit so count = wptr - rptr.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic                     push_ok,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             rd_en;

    assign count   = wptr - rptr;
    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop);
    assign rd_en   = pop && !empty;
    assign dout    = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (rd_en)   rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/msg_stream_sink.sv
// Captures processor stores into the message window and streams them out as bytes.
// Define MSG_STREAM_COUNT_EN to add the saturating byte_count output.
module msg_stream_sink
    import msg_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter logic [31:0] MSG_BASE  = MSG_BASE_DEF,
    parameter logic [31:0] MSG_LIMIT = MSG_LIMIT_DEF,
    parameter logic [31:0] END_ADR   = END_ADR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        full,
    output logic        overflow,
    output logic        done,
`ifdef MSG_STREAM_COUNT_EN
    output logic [15:0] byte_count,
`endif
    output msg_state_t  state_dbg
);

    // out_valid/out_ready: a byte moves on every rising edge where both are high;
    // out_data is held stable while out_valid is high and no pop occurs.

    msg_state_t state, state_next;
    logic                   cap, endw, push_req, push_ok, pop, empty;
    logic [$clog2(DEPTH):0] count;
    logic                   unused_hi;

    assign unused_hi = ^WriteData[31:8];

    assign cap  = MemWrite && (DataAdr >= MSG_BASE) && (DataAdr <= MSG_LIMIT)
                  && (state != DONE) && (state != DRAIN);
    assign endw = MemWrite && (DataAdr >= END_ADR);
    // End-of-message takes priority if the windows were ever configured to overlap.
    assign push_req  = cap && !endw;
    assign out_valid = !empty && (state != DONE);
    assign pop       = out_valid && out_ready;
    assign done      = (state == DONE);
    assign state_dbg = state;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_req),
        .pop     (pop),
        .din     (WriteData[7:0]),
        .dout    (out_data),
        .full    (full),
        .empty   (empty),
        .push_ok (push_ok),
        .count   (count)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (endw)     state_next = DRAIN;
                else if (cap) state_next = STREAM;
            end
            STREAM: if (endw)        state_next = DRAIN;
            DRAIN:  if (count == '0) state_next = DONE;
            DONE:   state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            if (push_req && !push_ok) overflow <= 1'b1;
        end
    end

`ifdef MSG_STREAM_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) byte_count <= '0;
        else if (push_ok && (byte_count != 16'hFFFF)) byte_count <= byte_count + 16'd1;
    end
`endif

endmodule

// File: doc/msg_stream_sink.md
Name: msg_stream_sink

Overview:
- Sits downstream of the processor data bus, alongside the RAM message window.
- Captures every byte the program stores into the message RAM window and buffers it in a FIFO.
- Streams the buffered bytes out over a valid/ready byte interface, which feeds a character sink or testbench file writer.
- Detects the end-of-program store to the flag-register region, drains the FIFO, then asserts a sticky done.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- MSG_BASE, 32'h4600, first address of the captured window (inclusive).
- MSG_LIMIT, 32'h5000, last address of the captured window (inclusive).
- END_ADR, 32'h5200, any store at or above this address marks end-of-message.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- DataAdr  input  32  processor data address
- WriteData  input  32  processor store data; only bits [7:0] are captured
- MemWrite  input  1  processor store strobe
- out_data  output  8  byte at the FIFO head
- out_valid  output  1  out_data is valid
- out_ready  input  1  consumer accepts the byte
- full  output  1  FIFO holds DEPTH bytes
- overflow  output  1  sticky; a byte was dropped
- done  output  1  sticky; message complete and FIFO drained

Behaviour:
- Clocking/reset: one clock (clk); reset is asynchronous and active-high. On reset, all pointers are cleared; out_valid=0, out_data=0, full=0, overflow=0, done=0; state=IDLE.
- Capture condition (cap): MemWrite && DataAdr>=MSG_BASE && DataAdr<=MSG_LIMIT && state!=DONE && state!=DRAIN. Compares are unsigned, full 32 bits.
- End condition (endw): MemWrite && DataAdr>=END_ADR.
- Pop: out_valid && out_ready.
- FIFO is first-word-fall-through. Pointers are log2(DEPTH)+1 bits wide and wrap naturally. Count = wptr-rptr.
- Push acceptance: a push is accepted when count<DEPTH, or when count==DEPTH and a pop happens in the same cycle. Otherwise the byte is dropped and overflow sets on the next edge, staying set until reset.
- Latency: a byte captured on edge N is visible on out_data with out_valid=1 after edge N (registered), provided the FIFO was empty.
- out_data holds the head entry while out_valid=1. It must not change until a pop.
- Ordering: strict FIFO.
- State machine:
  - IDLE: the first cap moves to STREAM.
  - STREAM: cap pushes bytes; endw moves to DRAIN.
  - DRAIN: captures are ignored; on count==0, move to DONE.
  - DONE: done=1 and out_valid=0; all bus activity is ignored until reset.
- endw in IDLE goes straight to DRAIN, then to DONE one cycle later (empty message).
- A cycle where cap and endw are both true is impossible because the windows are disjoint. If parameters overlap them, endw wins and no push occurs.
- Reset mid-stream discards FIFO contents. No byte may be emitted after reset deasserts until a new cap.

Optional Feature:
- Macro: MSG_STREAM_COUNT_EN.
- With the macro: add output byte_count[15:0]. It increments on every accepted push, saturates at 16'hFFFF, and resets to 0. It lets the bench check message length.
- Without the macro: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package msg_pkg:
  - state enum msg_state_t {IDLE, STREAM, DRAIN, DONE}
  - default address localparams MSG_BASE_DEF, MSG_LIMIT_DEF, END_ADR_DEF
- One sub-module: sync_fifo #(WIDTH, DEPTH), a FWFT FIFO with push/pop/full/empty/count.
- msg_stream_sink holds the decode, state machine, overflow/done flags and the optional counter.

Test Plan:
- Store 0x48 ('H') to 0x4600, then 0x69 to 0x4601, with out_ready=1 -> out_data 0x48 then 0x69 on consecutive cycles; first out_valid one cycle after the store.
- Store 0x41 to 0x45FF, and 0x42 to 0x5001 -> neither is captured; out_valid stays 0.
- out_ready=0; store DEPTH+1 bytes 0x00..0x10 -> full=1 after 16 pushes; 0x10 dropped; overflow=1; draining yields 0x00..0x0F.
- With full=1, out_ready=1 and a store of 0x7A in the same cycle -> push accepted, overflow stays 0, 0x7A is the last byte out.
- Store 'O','K', then store 0 to 0x5200 with out_ready held 0 for 5 cycles -> done=0 until both bytes are popped; done=1 the cycle after the FIFO empties; a later store to 0x4600 is ignored.
- Assert reset with 3 bytes queued -> out_valid=0 and done=0 immediately (asynchronous); after release, no stale byte appears. With MSG_STREAM_COUNT_EN, byte_count=0.
